// File: rtl/lbist_pkg.sv
// Shared types for the logic-BIST sequencer: FSM states and error codes.
package lbist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_START,
    RUN,
    EVAL,
    DONE_PASS,
    DONE_FAIL
  } lbist_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_START_TO = 2'b01,
    ERR_RUN_TO   = 2'b10,
    ERR_MISMATCH = 2'b11
  } lbist_err_e;

  function automatic logic is_busy(lbist_state_e s);
    return s inside {ARM, WAIT_START, RUN, EVAL};
  endfunction

  function automatic logic is_done(lbist_state_e s);
    return s inside {DONE_PASS, DONE_FAIL};
  endfunction

endpackage

// File: rtl/lbist_timeout_cnt.sv
// Saturating cycle counter with a programmable expiry compare (limit 0 = never expires).
module lbist_timeout_cnt #(
  parameter int unsigned CNT_WIDTH = 24
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic [CNT_WIDTH-1:0] limit_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 expired_c
);

  assign expired_c = (limit_i != '0) && (cnt_o == limit_i - CNT_WIDTH'(1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (en_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/lbist_seq_ctrl.sv
// Logic-BIST sequencer: drives test_normal into the core and tracks the go_nogo handshake.
// Optional macro LBIST_CYCLE_COUNT_EN adds run_cycles_o (cycles spent in RUN).
module lbist_seq_ctrl
  import lbist_pkg::*;
#(
  parameter int unsigned CNT_WIDTH     = 24,
  parameter int unsigned START_TIMEOUT = 1024,
  parameter int unsigned RUN_TIMEOUT   = 2**20,
  parameter int unsigned AUTO_START    = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 go_nogo_i,
  output logic                 test_normal_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic                 fail_o,
  output logic [1:0]           err_code_o
`ifdef LBIST_CYCLE_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0] run_cycles_o
`endif
);

  localparam longint unsigned CNT_MAX = (64'd1 << CNT_WIDTH) - 64'd1;
  localparam lbist_state_e RST_STATE = (AUTO_START != 0) ? ARM : IDLE;

  if ((64'(START_TIMEOUT) > CNT_MAX) || (64'(RUN_TIMEOUT) > CNT_MAX)) begin : g_cnt_width_chk
    $error("lbist_seq_ctrl: CNT_WIDTH too narrow for the configured timeouts");
  end

  lbist_state_e           state_q, state_d;
  lbist_err_e             err_d;
  logic                   go_q, go_rise;
  logic                   tn_d, busy_d, done_d, pass_d, fail_d;
  logic                   cnt_clr, cnt_en, cnt_expired;
  logic [CNT_WIDTH-1:0]   cnt_limit, cnt;

  assign go_rise = go_nogo_i & ~go_q;

  // Counter restarts on every WAIT_START/RUN entry; limit follows the phase.
  assign cnt_en    = state_q inside {WAIT_START, RUN};
  assign cnt_clr   = ~cnt_en | go_rise;
  assign cnt_limit = (state_q == RUN) ? CNT_WIDTH'(RUN_TIMEOUT) : CNT_WIDTH'(START_TIMEOUT);

  lbist_timeout_cnt #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_timeout_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (cnt_clr),
    .en_i      (cnt_en),
    .limit_i   (cnt_limit),
    .cnt_o     (cnt),
    .expired_c (cnt_expired)
  );

  // Next state and next registered outputs; go_rise is tested before timeouts.
  always_comb begin
    state_d = state_q;
    err_d   = lbist_err_e'(err_code_o);
    case (state_q)
      IDLE, DONE_PASS, DONE_FAIL: begin
        if (start_i) begin
          state_d = ARM;
          err_d   = ERR_NONE;
        end
      end
      ARM: state_d = WAIT_START;
      WAIT_START: begin
        if (go_rise) begin
          state_d = RUN;
        end else if (cnt_expired) begin
          state_d = DONE_FAIL;
          err_d   = ERR_START_TO;
        end
      end
      RUN: begin
        if (go_rise) begin
          state_d = EVAL;
        end else if (cnt_expired) begin
          state_d = DONE_FAIL;
          err_d   = ERR_RUN_TO;
        end
      end
      EVAL: begin
        if (go_nogo_i) begin
          state_d = DONE_PASS;
        end else begin
          state_d = DONE_FAIL;
          err_d   = ERR_MISMATCH;
        end
      end
      default: state_d = IDLE;
    endcase
    tn_d   = state_d inside {WAIT_START, RUN, EVAL};
    busy_d = is_busy(state_d);
    done_d = is_done(state_d) && !is_done(state_q);
    pass_d = (state_d == DONE_PASS);
    fail_d = (state_d == DONE_FAIL);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= RST_STATE;
      go_q          <= 1'b0;
      test_normal_o <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      pass_o        <= 1'b0;
      fail_o        <= 1'b0;
      err_code_o    <= 2'b00;
    end else begin
      state_q       <= state_d;
      go_q          <= go_nogo_i;
      test_normal_o <= tn_d;
      busy_o        <= busy_d;
      done_o        <= done_d;
      pass_o        <= pass_d;
      fail_o        <= fail_d;
      err_code_o    <= err_d;
    end
  end

`ifdef LBIST_CYCLE_COUNT_EN
  // On a run timeout the count is one short of RUN_TIMEOUT, so add the final cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      run_cycles_o <= '0;
    end else if (state_d == ARM) begin
      run_cycles_o <= '0;
    end else if ((state_q == RUN) && (state_d != RUN)) begin
      run_cycles_o <= go_rise ? cnt : cnt + CNT_WIDTH'(1);
    end
  end
`else
  logic unused_cnt;
  assign unused_cnt = ^cnt;
`endif

endmodule

// File: tb/tb_lbist_seq_ctrl.sv
// Table-driven directed bench for lbist_seq_ctrl (optionally with LBIST_CYCLE_COUNT_EN).
module tb_lbist_seq_ctrl;

  localparam int unsigned CW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          go;
  logic          test_normal, busy, done, pass, fail;
  logic [1:0]    err;
`ifdef LBIST_CYCLE_COUNT_EN
  logic [CW-1:0] run_cycles;
`endif

  always #5 clk = ~clk;

  lbist_seq_ctrl #(
    .CNT_WIDTH     (CW),
    .START_TIMEOUT (16),
    .RUN_TIMEOUT   (300),
    .AUTO_START    (1)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .go_nogo_i     (go),
    .test_normal_o (test_normal),
    .busy_o        (busy),
    .done_o        (done),
    .pass_o        (pass),
    .fail_o        (fail),
    .err_code_o    (err)
`ifdef LBIST_CYCLE_COUNT_EN
    ,
    .run_cycles_o  (run_cycles)
`endif
  );

  typedef struct {
    string      name;
    int         n;
    logic       start;
    logic       go;
    logic [6:0] exp;
    int         rc;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Expected output vector {test_normal, busy, done, pass, fail, err}.
  function automatic logic [6:0] o(logic tn, logic b, logic d, logic p, logic f, logic [1:0] e);
    return {tn, b, d, p, f, e};
  endfunction

  function automatic void add(string name, int n, logic s, logic g, logic [6:0] exp, int rc = -1);
    vec_t v;
    v.name = name; v.n = n; v.start = s; v.go = g; v.exp = exp; v.rc = rc;
    vecs.push_back(v);
  endfunction

  function automatic logic [6:0] outs();
    return {test_normal, busy, done, pass, fail, err};
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {tn,busy,done,pass,fail,err}=%b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_rc(input string name, input int exp);
`ifdef LBIST_CYCLE_COUNT_EN
    n_chk++;
    if (run_cycles !== CW'(exp)) begin
      n_fail++;
      $display("FAIL %s run_cycles: got %0d, expected %0d", name, run_cycles, exp);
    end
`else
    if (exp < 0) $display("check_rc %s skipped", name);
`endif
  endtask

  task automatic apply(input logic s, input logic g, input int n);
    start = s;
    go    = g;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Nominal pass: start edge at cycle 10, finish edge at cycle 110, held high through EVAL.
    add("arm_exit",     1,  0, 0, o(1, 1, 0, 0, 0, 2'b00));
    add("wait_start",   8,  0, 0, o(1, 1, 0, 0, 0, 2'b00));
    add("start_edge",   1,  0, 1, o(1, 1, 0, 0, 0, 2'b00));
    add("run_low",      99, 0, 0, o(1, 1, 0, 0, 0, 2'b00));
    add("finish_edge",  1,  0, 1, o(1, 1, 0, 0, 0, 2'b00));
    add("eval_pass",    1,  0, 1, o(0, 0, 1, 1, 0, 2'b00), 99);
    add("pass_hold",    3,  0, 0, o(0, 0, 0, 1, 0, 2'b00), 99);
    // Restart from DONE_PASS, start_i ignored during RUN, signature mismatch.
    add("rearm2",       1,  1, 0, o(0, 1, 0, 0, 0, 2'b00), 0);
    add("ws2",          1,  0, 0, o(1, 1, 0, 0, 0, 2'b00));
    add("run2",         1,  0, 1, o(1, 1, 0, 0, 0, 2'b00));
    add("run2_low",     5,  0, 0, o(1, 1, 0, 0, 0, 2'b00));
    add("start_in_run", 1,  1, 0, o(1, 1, 0, 0, 0, 2'b00));
    add("finish2",      1,  0, 1, o(1, 1, 0, 0, 0, 2'b00));
    add("eval_fail",    1,  0, 0, o(0, 0, 1, 0, 1, 2'b11));
    add("fail_hold",    2,  0, 0, o(0, 0, 0, 0, 1, 2'b11));
    // Re-run from DONE_FAIL into a start timeout (16 WAIT_START cycles).
    add("rearm3",       1,  1, 0, o(0, 1, 0, 0, 0, 2'b00));
    add("ws3",          1,  0, 0, o(1, 1, 0, 0, 0, 2'b00));
    add("ws3_wait",     15, 0, 0, o(1, 1, 0, 0, 0, 2'b00));
    add("start_to",     1,  0, 0, o(0, 0, 1, 0, 1, 2'b01));
    add("start_to_hld", 1,  0, 0, o(0, 0, 0, 0, 1, 2'b01));
    // Run timeout after 300 RUN cycles.
    add("rearm4",       1,  1, 0, o(0, 1, 0, 0, 0, 2'b00));
    add("ws4",          1,  0, 0, o(1, 1, 0, 0, 0, 2'b00));
    add("run4",         1,  0, 1, o(1, 1, 0, 0, 0, 2'b00));
    add("run4_low",     299, 0, 0, o(1, 1, 0, 0, 0, 2'b00));
    add("run_to",       1,  0, 0, o(0, 0, 1, 0, 1, 2'b10), 300);
    // Held-high go_nogo must not advance RUN; a fresh edge does.
    add("rearm5",       1,  1, 0, o(0, 1, 0, 0, 0, 2'b00), 0);
    add("ws5",          1,  0, 0, o(1, 1, 0, 0, 0, 2'b00));
    add("run5",         1,  0, 1, o(1, 1, 0, 0, 0, 2'b00));
    add("held_high",    50, 0, 1, o(1, 1, 0, 0, 0, 2'b00));
    add("held_low",     1,  0, 0, o(1, 1, 0, 0, 0, 2'b00));
    add("finish5",      1,  0, 1, o(1, 1, 0, 0, 0, 2'b00));
    add("eval5",        1,  0, 1, o(0, 0, 1, 1, 0, 2'b00), 51);

    rst = 1'b1; start = 1'b0; go = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", outs(), 7'b0);
    check_rc("reset_state", 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      apply(vecs[i].start, vecs[i].go, vecs[i].n);
      check(vecs[i].name, outs(), vecs[i].exp);
      if (vecs[i].rc >= 0) check_rc(vecs[i].name, vecs[i].rc);
    end

    // Async reset in mid-RUN: outputs drop before the next clock edge.
    apply(1, 0, 1);
    apply(0, 0, 1);
    apply(0, 1, 1);
    apply(0, 0, 39);
    check("pre_reset_run", outs(), o(1, 1, 0, 0, 0, 2'b00));
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_drop", outs(), 7'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", outs(), 7'b0);
    check_rc("reset_held", 0);
    rst = 1'b0;
    apply(0, 0, 1);
    check("auto_rearm", outs(), o(1, 1, 0, 0, 0, 2'b00));
    apply(0, 1, 1);
    apply(0, 0, 3);
    apply(0, 1, 1);
    apply(0, 0, 1);
    check("post_reset_mismatch", outs(), o(0, 0, 1, 0, 1, 2'b11));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
